// File: rtl/line_packer.sv
// Packs a stream of 2-bit pixels into two 160-bit bitplanes and publishes each
// completed line, holding updateBufferSignal high for HOLD_CYCLES cycles.
module line_packer #(
   parameter int HOLD_CYCLES = 8,
   parameter int MAX_LY      = 143
) (
   input  logic         ppuClk,
   input  logic         resetN,
   input  logic         lineStart,
   input  logic [7:0]   lyIn,
   input  logic         pixelValid,
   input  logic [1:0]   pixelData,
   output logic [159:0] LineBuffer0,
   output logic [159:0] LineBuffer1,
   output logic [7:0]   LY,
   output logic         updateBufferSignal,
   output logic         busy,
   output logic         pixelDropped,
   output logic         lineAborted
);

   localparam logic [7:0] LAST_X    = 8'd159;
   localparam logic [7:0] MAX_LY_V  = 8'(MAX_LY);
   localparam logic [6:0] HOLD_LOAD = 7'(HOLD_CYCLES);

   typedef enum logic {IDLE, FILL} state_t;

   state_t         state;
   logic [7:0]     x;
   logic [7:0]     lineLy;
   logic [159:0]   work0;
   logic [159:0]   work1;
   logic [159:0]   nextWork0;
   logic [159:0]   nextWork1;
   logic [6:0]     holdCnt;
   logic           lyOk;

   assign lyOk               = (lyIn <= MAX_LY_V);
   assign busy               = (state == FILL);
   assign updateBufferSignal = (holdCnt != 7'd0);

   // Work planes with the current pixel merged in, so the final pixel of a
   // line is published in the same edge it is accepted.
   always_comb begin
      nextWork0    = work0;
      nextWork1    = work1;
      nextWork0[x] = pixelData[0];
      nextWork1[x] = pixelData[1];
   end

   always_ff @(posedge ppuClk) begin
      if (!resetN) begin
         // NOTE: the line planes are plain registers, not RAM, so they take the
         // reset like everything else; stale data can never be published.
         state        <= IDLE;
         x            <= 8'd0;
         lineLy       <= 8'd0;
         work0        <= '0;
         work1        <= '0;
         LineBuffer0  <= '0;
         LineBuffer1  <= '0;
         LY           <= 8'd0;
         holdCnt      <= 7'd0;
         pixelDropped <= 1'b0;
         lineAborted  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so the later publish reload of
         // holdCnt cleanly overrides this decrement within the same edge.
         pixelDropped <= 1'b0;
         lineAborted  <= 1'b0;
         if (holdCnt != 7'd0) holdCnt <= holdCnt - 7'd1;

         case (state)
            IDLE: begin
               pixelDropped <= pixelValid;
               if (lineStart && lyOk) begin
                  lineLy <= lyIn;
                  x      <= 8'd0;
                  work0  <= '0;
                  work1  <= '0;
                  state  <= FILL;
               end
            end

            FILL: begin
               if (lineStart) begin
                  lineAborted  <= 1'b1;
                  pixelDropped <= pixelValid;
                  x            <= 8'd0;
                  work0        <= '0;
                  work1        <= '0;
                  if (lyOk) lineLy <= lyIn;
                  else      state  <= IDLE;
               end else if (pixelValid) begin
                  work0 <= nextWork0;
                  work1 <= nextWork1;
                  if (x == LAST_X) begin
                     LineBuffer0 <= nextWork0;
                     LineBuffer1 <= nextWork1;
                     LY          <= lineLy;
                     holdCnt     <= HOLD_LOAD;
                     x           <= 8'd0;
                     state       <= IDLE;
                  end else begin
                     x <= x + 8'd1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_packer.sv
// Bench for line_packer: fixed vector table, hand-written line sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_line_packer;

   logic         ppuClk = 1'b0;
   logic         resetN = 1'b0;
   logic         lineStart = 1'b0;
   logic [7:0]   lyIn = 8'd0;
   logic         pixelValid = 1'b0;
   logic [1:0]   pixelData = 2'd0;
   logic [159:0] LineBuffer0;
   logic [159:0] LineBuffer1;
   logic [7:0]   LY;
   logic         updateBufferSignal;
   logic         busy;
   logic         pixelDropped;
   logic         lineAborted;

   line_packer #(.HOLD_CYCLES(8), .MAX_LY(143)) dut (
      .ppuClk(ppuClk),
      .resetN(resetN),
      .lineStart(lineStart),
      .lyIn(lyIn),
      .pixelValid(pixelValid),
      .pixelData(pixelData),
      .LineBuffer0(LineBuffer0),
      .LineBuffer1(LineBuffer1),
      .LY(LY),
      .updateBufferSignal(updateBufferSignal),
      .busy(busy),
      .pixelDropped(pixelDropped),
      .lineAborted(lineAborted)
   );

   always #5 ppuClk = ~ppuClk;

   int errors = 0;
   int checks = 0;
   int nUpd   = 0;
   int nDrop  = 0;
   int nAbort = 0;

   // Reference model: a line is just a queue of accepted pixels; 160 of them
   // make a published line.
   logic         mActive = 1'b0;
   logic [7:0]   mLy     = 8'd0;
   logic [1:0]   mPix[$];
   logic [159:0] mLb0    = '0;
   logic [159:0] mLb1    = '0;
   logic [7:0]   mLyOut  = 8'd0;
   int           mHold   = 0;
   logic         mDrop   = 1'b0;
   logic         mAbort  = 1'b0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic modelEdge(input logic rn, input logic ls, input logic [7:0] ly,
                            input logic pv, input logic [1:0] pd);
      if (!rn) begin
         mActive = 1'b0; mLy = 8'd0; mPix.delete();
         mLb0 = '0; mLb1 = '0; mLyOut = 8'd0; mHold = 0;
         mDrop = 1'b0; mAbort = 1'b0;
         return;
      end
      mDrop  = 1'b0;
      mAbort = 1'b0;
      if (mHold > 0) mHold--;
      if (!mActive) begin
         mDrop = pv;
         if (ls && ly <= 8'd143) begin
            mActive = 1'b1; mLy = ly; mPix.delete();
         end
      end else if (ls) begin
         mAbort = 1'b1;
         mDrop  = pv;
         mPix.delete();
         if (ly <= 8'd143) mLy = ly;
         else              mActive = 1'b0;
      end else if (pv) begin
         mPix.push_back(pd);
         if (mPix.size() == 160) begin
            for (int i = 0; i < 160; i++) begin
               mLb0[i] = mPix[i][0];
               mLb1[i] = mPix[i][1];
            end
            mLyOut  = mLy;
            mHold   = 8;
            mActive = 1'b0;
            mPix.delete();
         end
      end
   endtask

   task automatic step(input logic rn, input logic ls, input logic [7:0] ly,
                       input logic pv, input logic [1:0] pd);
      resetN = rn; lineStart = ls; lyIn = ly; pixelValid = pv; pixelData = pd;
      @(posedge ppuClk);
      modelEdge(rn, ls, ly, pv, pd);
      #1;
      check("LineBuffer0", LineBuffer0, mLb0);
      check("LineBuffer1", LineBuffer1, mLb1);
      check("LY", 160'(LY), 160'(mLyOut));
      check("updateBufferSignal", 160'(updateBufferSignal), 160'(mHold != 0));
      check("busy", 160'(busy), 160'(mActive));
      check("pixelDropped", 160'(pixelDropped), 160'(mDrop));
      check("lineAborted", 160'(lineAborted), 160'(mAbort));
      if (updateBufferSignal) nUpd++;
      if (pixelDropped)       nDrop++;
      if (lineAborted)        nAbort++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
   endtask

   task automatic doReset();
      step(1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
      idle(1);
   endtask

   typedef struct {
      logic       ls;
      logic [7:0] ly;
      logic       pv;
      logic [1:0] pd;
      logic       eBusy;
      logic       eDrop;
      logic       eAbort;
   } vec_t;

   vec_t vecs[10];

   logic [159:0] patA;
   logic [159:0] patC;
   logic [159:0] ones;
   int           cnt;
   int           busyLow;
   int           updBefore;

   initial begin
      vecs[0] = '{1'b1, 8'd150, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'd0,   1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'd10,  1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 8'd0,   1'b1, 2'd3, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'd200, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'd143, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'd144, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 8'd143, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 8'd0,   1'b1, 2'd3, 1'b1, 1'b1, 1'b1};
      vecs[9] = '{1'b0, 8'd0,   1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
      patA = {40{4'hA}};
      patC = {40{4'hC}};
      ones = '1;

      doReset();
      check("reset LY", 160'(LY), 160'd0);
      check("reset busy", 160'(busy), 160'd0);
      check("reset update", 160'(updateBufferSignal), 160'd0);

      for (int i = 0; i < 10; i++) begin
         step(1'b1, vecs[i].ls, vecs[i].ly, vecs[i].pv, vecs[i].pd);
         check($sformatf("vec%0d busy", i), 160'(busy), 160'(vecs[i].eBusy));
         check($sformatf("vec%0d pixelDropped", i), 160'(pixelDropped), 160'(vecs[i].eDrop));
         check($sformatf("vec%0d lineAborted", i), 160'(lineAborted), 160'(vecs[i].eAbort));
      end

      // Full line with shade = x[1:0].
      doReset();
      step(1'b1, 1'b1, 8'd5, 1'b0, 2'd0);
      for (int px = 0; px < 159; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'(px));
      nUpd = 0;
      step(1'b1, 1'b0, 8'd0, 1'b1, 2'd3);
      check("full LY", 160'(LY), 160'd5);
      check("full plane0", LineBuffer0, patA);
      check("full plane1", LineBuffer1, patC);
      check("full update", 160'(updateBufferSignal), 160'd1);
      idle(20);
      check("full hold cycles", 160'(nUpd), 160'd8);

      // Gapped pixels: busy must stay high until the line publishes.
      doReset();
      step(1'b1, 1'b1, 8'd5, 1'b0, 2'd0);
      cnt = 0; busyLow = 0;
      for (int c = 0; c < 400 && cnt < 160; c++) begin
         step(1'b1, 1'b0, 8'd0, c[0], 2'(cnt));
         if (c[0]) cnt++;
         if (cnt < 160 && !busy) busyLow++;
      end
      check("gap pixels accepted", 160'(cnt), 160'd160);
      check("gap busy low early", 160'(busyLow), 160'd0);
      check("gap plane0", LineBuffer0, patA);
      check("gap plane1", LineBuffer1, patC);
      check("gap LY", 160'(LY), 160'd5);

      // Abort line 3 part way, complete line 4 of all ones.
      doReset();
      nAbort = 0; nUpd = 0;
      step(1'b1, 1'b1, 8'd3, 1'b0, 2'd0);
      for (int px = 0; px < 80; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'(px));
      step(1'b1, 1'b1, 8'd4, 1'b0, 2'd0);
      for (int px = 0; px < 159; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'd3);
      updBefore = nUpd;
      step(1'b1, 1'b0, 8'd0, 1'b1, 2'd3);
      check("abort pulses", 160'(nAbort), 160'd1);
      check("abort no early publish", 160'(updBefore), 160'd0);
      check("abort LY", 160'(LY), 160'd4);
      check("abort plane0", LineBuffer0, ones);
      check("abort plane1", LineBuffer1, ones);
      idle(10);

      // Out-of-range line and stray pixels leave the published line alone.
      nDrop = 0;
      step(1'b1, 1'b1, 8'd150, 1'b0, 2'd0);
      for (int px = 0; px < 10; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'd1);
      check("ignored drops", 160'(nDrop), 160'd10);
      check("ignored busy", 160'(busy), 160'd0);
      check("ignored LY", 160'(LY), 160'd4);
      check("ignored plane0", LineBuffer0, ones);

      // Overlap a new line with the hold window, then reset mid-line.
      doReset();
      step(1'b1, 1'b1, 8'd7, 1'b0, 2'd0);
      for (int px = 0; px < 159; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'(px));
      nUpd = 0;
      step(1'b1, 1'b0, 8'd0, 1'b1, 2'd3);
      step(1'b1, 1'b1, 8'd8, 1'b0, 2'd0);
      for (int px = 0; px < 50; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'd2);
      check("overlap hold cycles", 160'(nUpd), 160'd8);
      check("overlap busy", 160'(busy), 160'd1);
      check("overlap LY", 160'(LY), 160'd7);
      nAbort = 0; nUpd = 0;
      step(1'b0, 1'b0, 8'd0, 1'b1, 2'd2);
      check("reset plane0", LineBuffer0, 160'd0);
      check("reset plane1", LineBuffer1, 160'd0);
      check("reset LY", 160'(LY), 160'd0);
      check("reset busy", 160'(busy), 160'd0);
      for (int px = 0; px < 120; px++) step(1'b1, 1'b0, 8'd0, 1'b1, 2'd2);
      check("reset no publish", 160'(nUpd), 160'd0);
      check("reset no abort", 160'(nAbort), 160'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         step(($urandom_range(0, 1999) != 0),
              ($urandom_range(0, 249) == 0),
              8'($urandom_range(0, 170)),
              ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
